// File: rtl/mult_fu.sv
// mult_fu: pipelined 32x32 RV32M multiplier feeding the CDB arbiter.
// The result is held in an output slot until cdb_ack; a withheld ack stalls the
// whole pipeline and drops issue_ready.
// STAGES counts every register from issue to the presented result, including
// the output slot, so an op issued in cycle 0 is presented in cycle STAGES.
// Optional feature: define MULT_FU_SKID_EN to turn the output slot into a
// 2-entry FIFO so one result can be absorbed while the CDB withholds ack.
module mult_fu #(
    parameter int unsigned STAGES    = 4,
    parameter int unsigned ROB_TAG_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [1:0]           issue_func,
    input  logic [31:0]          issue_rs1,
    input  logic [31:0]          issue_rs2,
    input  logic [ROB_TAG_W-1:0] issue_rob_tag,
    input  logic                 cdb_ack,
    output logic                 done,
    output logic [ROB_TAG_W-1:0] out_rob_tag,
    output logic [31:0]          out_v
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned EXT_W  = PROD_W - DATA_W;
    // Internal stage registers; the output slot supplies the last register.
    localparam int unsigned NSTG   = STAGES - 1;
`ifdef MULT_FU_SKID_EN
    localparam int unsigned SLOT_N = 2;
`else
    localparam int unsigned SLOT_N = 1;
`endif

    localparam logic [1:0] FUNC_MUL    = 2'b00;
    localparam logic [1:0] FUNC_MULH   = 2'b01;
    localparam logic [1:0] FUNC_MULHSU = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    res;
    } entry_t;

    entry_t stg_q [NSTG];
    entry_t stg_d [NSTG];
    entry_t slot_q [2];
    entry_t slot_d [2];

    logic              sext_a_c;
    logic              sext_b_c;
    logic [PROD_W-1:0] op_a_c;
    logic [PROD_W-1:0] op_b_c;
    logic [PROD_W-1:0] prod_c;
    logic [DATA_W-1:0] res_c;
    logic              slot_free_c;
    logic              advance_c;
    logic              pop_c;

    // Operand extension and product; the low 64 bits of the wrapped product
    // equal bits [63:0] of the exact 66-bit signed product.
    always_comb begin
        sext_a_c = (issue_func == FUNC_MULH) || (issue_func == FUNC_MULHSU);
        sext_b_c = (issue_func == FUNC_MULH);
        op_a_c   = {{EXT_W{sext_a_c & issue_rs1[DATA_W-1]}}, issue_rs1};
        op_b_c   = {{EXT_W{sext_b_c & issue_rs2[DATA_W-1]}}, issue_rs2};
        prod_c   = op_a_c * op_b_c;
        res_c    = (issue_func == FUNC_MUL) ? prod_c[DATA_W-1:0]
                                            : prod_c[PROD_W-1:DATA_W];
    end

    // Global advance: the slot can take a result, so everything may shift.
    always_comb begin
        slot_free_c = !slot_q[SLOT_N-1].valid || cdb_ack;
        advance_c   = slot_free_c;
        issue_ready = advance_c;
        pop_c       = cdb_ack && slot_q[0].valid;
    end

    // Stage shift register: load on advance, hold on stall, flush on clear.
    always_comb begin
        stg_d = stg_q;
        if (advance_c) begin
            stg_d[0].valid = issue_valid;
            stg_d[0].tag   = issue_rob_tag;
            stg_d[0].res   = res_c;
            for (int unsigned k = 1; k < NSTG; k++) begin
                stg_d[k] = stg_q[k-1];
            end
        end
        if (clear) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                stg_d[k].valid = 1'b0;
            end
        end
    end

    // Output slot: consume the head on ack, refill from the last stage in order.
    always_comb begin
        slot_d = slot_q;
        if (pop_c) begin
            slot_d[0]       = slot_q[1];
            slot_d[1].valid = 1'b0;
        end
        if (advance_c && stg_q[NSTG-1].valid) begin
            if (!slot_d[0].valid) begin
                slot_d[0] = stg_q[NSTG-1];
            end else if (SLOT_N > 1) begin
                slot_d[1] = stg_q[NSTG-1];
            end
        end
        if (clear) begin
            slot_d[0].valid = 1'b0;
            slot_d[1].valid = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                stg_q[k] <= '0;
            end
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else begin
            stg_q  <= stg_d;
            slot_q <= slot_d;
        end
    end

    assign done        = slot_q[0].valid;
    assign out_rob_tag = slot_q[0].tag;
    assign out_v       = slot_q[0].res;

endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: directed vector table, multi-cycle corner
// sequences, and randomized traffic against an in-order scoreboard.
module tb_mult_fu;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_func;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic [4:0]  issue_rob_tag;
    logic        cdb_ack;
    logic        done;
    logic [4:0]  out_rob_tag;
    logic [31:0] out_v;

    mult_fu #(.STAGES(4), .ROB_TAG_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_func    (issue_func),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rob_tag (issue_rob_tag),
        .cdb_ack       (cdb_ack),
        .done          (done),
        .out_rob_tag   (out_rob_tag),
        .out_v         (out_v)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] v;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  sbq[$];
    logic  hold_v = 1'b0;
    logic [4:0]  held_tag;
    logic [31:0] held_v;
    vec_t  vt[12];

    // Reference: RV32M semantics via 64-bit integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            2'd1:    p = sa * sb;
            2'd2:    p = sa * longint'(ub);
            default: p = ua * ub;
        endcase
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle scoreboard, evaluated mid-cycle on the values the next edge will see.
    task automatic monitor();
        exp_t e;
        if (!reset) begin
            sbq.delete();
            hold_v = 1'b0;
            return;
        end
        if (hold_v) begin
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_tag", 32'(out_rob_tag), 32'(held_tag));
            chk("hold_val", out_v, held_v);
        end
`ifndef MULT_FU_SKID_EN
        chk("ready_rule", 32'(issue_ready), 32'(!done || cdb_ack));
`endif
        if (done && cdb_ack) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_spurious: got tag %h with nothing outstanding", out_rob_tag);
            end else begin
                e = sbq.pop_front();
                chk("sb_tag", 32'(out_rob_tag), 32'(e.tag));
                chk("sb_val", out_v, e.v);
            end
        end
        hold_v   = done && !cdb_ack && !clear;
        held_tag = out_rob_tag;
        held_v   = out_v;
        if (clear) begin
            sbq.delete();
        end else if (issue_valid && issue_ready) begin
            e.tag = issue_rob_tag;
            e.v   = ref_mul(issue_func, issue_rs1, issue_rs2);
            sbq.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        issue_valid   = v;
        issue_func    = f;
        issue_rs1     = a;
        issue_rs2     = b;
        issue_rob_tag = t;
    endtask

    function automatic logic [31:0] pick_op();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int          next;
        int          got_tag [6];
        int          got_cyc [6];
        int          ngot;
        logic        acc;
        logic        pend;

        vt[0]  = '{2'd0, 32'd7,          32'd6,          5'd3,  32'd42};
        vt[1]  = '{2'd1, 32'hFFFF_FFFF,  32'd2,          5'd4,  32'hFFFF_FFFF};
        vt[2]  = '{2'd3, 32'hFFFF_FFFF,  32'd2,          5'd5,  32'h0000_0001};
        vt[3]  = '{2'd2, 32'hFFFF_FFFF,  32'd2,          5'd6,  32'hFFFF_FFFF};
        vt[4]  = '{2'd0, 32'hFFFF_FFFF,  32'd2,          5'd7,  32'hFFFF_FFFE};
        vt[5]  = '{2'd1, 32'h8000_0000,  32'h8000_0000,  5'd8,  32'h4000_0000};
        vt[6]  = '{2'd3, 32'h8000_0000,  32'h8000_0000,  5'd10, 32'h4000_0000};
        vt[7]  = '{2'd2, 32'h8000_0000,  32'h8000_0000,  5'd11, 32'hC000_0000};
        vt[8]  = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd12, 32'hFFFF_FFFE};
        vt[9]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd13, 32'h0000_0000};
        vt[10] = '{2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd14, 32'hFFFF_FFFF};
        vt[11] = '{2'd0, 32'd1000,       32'd1000,       5'd31, 32'h000F_4240};

        reset   = 1'b0;
        clear   = 1'b0;
        cdb_ack = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #3;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tag", 32'(out_rob_tag), 32'd0);
        chk("rst_val", out_v, 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Vector table: single op, ack tied high, presented exactly in cycle 4.
        cdb_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vt[i].f, vt[i].a, vt[i].b, vt[i].tag);
            tick();
            issue_valid = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                chk("vec_done", 32'(done), 32'(c == 4));
                if (c == 4) begin
                    chk("vec_tag", 32'(out_rob_tag), 32'(vt[i].tag));
                    chk("vec_val", out_v, vt[i].exp);
                end
                tick();
            end
        end

        // Ack in the first done cycle with tag 2 right behind: no bubble.
        for (int c = 0; c <= 6; c++) begin
            if (c == 0)      drive(1'b1, 2'd0, 32'd2, 32'd3, 5'd1);
            else if (c == 1) drive(1'b1, 2'd0, 32'd4, 32'd5, 5'd2);
            else             issue_valid = 1'b0;
            #1;
            if (c == 4) begin
                chk("ackt_done1", 32'(done), 32'd1);
                chk("ackt_tag1", 32'(out_rob_tag), 32'd1);
            end
            if (c == 5) begin
                chk("ackt_done2", 32'(done), 32'd1);
                chk("ackt_tag2", 32'(out_rob_tag), 32'd2);
                chk("ackt_val2", out_v, 32'd20);
            end
            if (c == 6) chk("ackt_idle", 32'(done), 32'd0);
            tick();
        end

        // Back-pressure: tags 1..6, ack withheld cycles 4..9, then drained in order.
        next = 1;
        ngot = 0;
        for (int c = 0; c < 30; c++) begin
            cdb_ack = !(c >= 4 && c < 10);
            if (next <= 6) drive(1'b1, 2'd0, 32'(next), 32'd10, 5'(next));
            else           issue_valid = 1'b0;
            #1;
            if (c >= 5 && c < 10) begin
                chk("bp_done", 32'(done), 32'd1);
                chk("bp_tag", 32'(out_rob_tag), 32'd1);
                chk("bp_ready", 32'(issue_ready), 32'd0);
            end
            if (done && cdb_ack && ngot < 6) begin
                got_tag[ngot] = int'(out_rob_tag);
                got_cyc[ngot] = c;
                ngot++;
            end
            acc = issue_valid && issue_ready;
            tick();
            if (acc) next++;
        end
        chk("bp_count", 32'(ngot), 32'd6);
        for (int i = 0; i < ngot; i++) begin
            chk("bp_order", 32'(got_tag[i]), 32'(i + 1));
            chk("bp_gapless", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
        end

        // Clear while stalled with three ops behind a held result.
        cdb_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, 32'd2, 32'd3, 5'(11 + i));
            tick();
        end
        issue_valid = 1'b0;
        chk("clr_pre_done", 32'(done), 32'd1);
        chk("clr_pre_tag", 32'(out_rob_tag), 32'd11);
        tick();
        clear = 1'b1;
        #1;
        chk("clr_ready", 32'(issue_ready), 32'd0);
        tick();
        clear = 1'b0;
        chk("clr_done", 32'(done), 32'd0);
        cdb_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk("clr_no_stale", 32'(done), 32'd0);
            tick();
        end
        drive(1'b1, 2'd0, 32'd3, 32'd3, 5'd9);
        tick();
        issue_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("clr_new_done", 32'(done), 32'(c == 4));
            if (c == 4) begin
                chk("clr_new_tag", 32'(out_rob_tag), 32'd9);
                chk("clr_new_val", out_v, 32'd9);
            end
            tick();
        end

        // Asynchronous reset between edges while a result is held.
        cdb_ack = 1'b0;
        drive(1'b1, 2'd0, 32'd5, 32'd5, 5'd7);
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();
        chk("ar_pre_done", 32'(done), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_val", out_v, 32'd0);
        chk("ar_tag", 32'(out_rob_tag), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_post_ready", 32'(issue_ready), 32'd1);
        chk("ar_post_done", 32'(done), 32'd0);

        // Randomized traffic with back-pressure and occasional flushes.
        pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                drive(1'b1, 2'($urandom_range(0, 3)), pick_op(), pick_op(),
                      5'($urandom_range(0, 31)));
                pend = 1'b1;
            end
            issue_valid = pend;
            cdb_ack     = ($urandom_range(0, 9) < 7);
            clear       = ($urandom_range(0, 49) == 0);
            #1;
            acc = issue_valid && issue_ready && !clear;
            tick();
            if (acc) pend = 1'b0;
        end
        clear       = 1'b0;
        issue_valid = 1'b0;
        cdb_ack     = 1'b1;
        repeat (10) tick();
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        chk("drain_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
